lbist_sequencer: RTL and testbench
==================================

LBIST_SEQUENCER -- requirements
Module: lbist_sequencer

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: shift cycles per scan load/unload (longest chain); legal range ≥2.
REQ-002 SHALL have parameter N_PATTERNS, default 1024: pseudo-random patterns applied; legal range ≥1.
REQ-003 SHALL have parameter MISR_W, default 32: signature width.
REQ-004 SHALL have parameter GOLDEN_SIG, default '0 (MISR_W bits): expected final signature.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port test_normal_i, input, 1 bit: 1 = test mode permitted, 0 = functional mode.
REQ-008 SHALL have port start_i, input, 1 bit: level-sampled request to run a BIST session.
REQ-009 SHALL have port misr_sig_i, input, MISR_W bits: current signature from the external MISR.
REQ-010 SHALL have port test_en_o, output, 1 bit: scan enable to the core (1 = shift).
REQ-011 SHALL have port pi_sel_o, output, 1 bit: selects PRPG data onto muxed primary inputs.
REQ-012 SHALL have port prpg_load_o, output, 1 bit: load seed into PRPG.
REQ-013 SHALL have port prpg_step_o, output, 1 bit: advance PRPG one step.
REQ-014 SHALL have port misr_clear_o, output, 1 bit: clear MISR.
REQ-015 SHALL have port misr_step_o, output, 1 bit: compact scan outputs into MISR.
REQ-016 SHALL have port busy_o, output, 1 bit: session in progress.
REQ-017 SHALL have port done_o, output, 1 bit: session complete, result valid.
REQ-018 SHALL have port go_nogo_o, output, 1 bit: 1 = signature matched.
REQ-019 SHALL have port pattern_cnt_o, output, $clog2(N_PATTERNS+1) bits: patterns captured so far.

Function
REQ-020 SHALL implement FSM states IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
REQ-021 IDLE→SEED SHALL occur on an edge where start_i=1 and test_normal_i=1; start_i is ignored in every other state except DONE.
REQ-022 SEED SHALL last 1 cycle: prpg_load_o=1, misr_clear_o=1, pattern counter and shift counter cleared; →SHIFT.
REQ-023 SHIFT SHALL last exactly CHAIN_LEN cycles: test_en_o=1, prpg_step_o=1, misr_step_o=1 only when pattern_cnt_o>0 (first unload holds uninitialised state and is not compacted); →CAPTURE.
REQ-024 CAPTURE SHALL last 1 cycle: test_en_o=0, prpg_step_o=0, misr_step_o=0; pattern_cnt_o increments at its end; →SHIFT if incremented count <N_PATTERNS, else →UNLOAD.
REQ-025 UNLOAD SHALL last CHAIN_LEN cycles: test_en_o=1, prpg_step_o=1, misr_step_o=1; →COMPARE.
REQ-026 COMPARE SHALL last 1 cycle; go_nogo_o registered at its end as (misr_sig_i==GOLDEN_SIG); →DONE.
REQ-027 DONE: done_o=1, go_nogo_o held; start_i=1 with test_normal_i=1 →SEED (go_nogo_o cleared); test_normal_i=0 →IDLE with go_nogo_o held.
REQ-028 pi_sel_o and busy_o SHALL be 1 in SEED through COMPARE, 0 in IDLE and DONE.
REQ-029 done_o SHALL assert exactly 1+N_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles after the start-sampling edge.
REQ-030 test_normal_i=0 in any busy state SHALL abort to IDLE next edge: all strobes 0, counters cleared, go_nogo_o=0, done_o never asserted.
REQ-031 Shift counter SHALL count 0..CHAIN_LEN-1 and wrap without overflow; pattern counter SHALL saturate at N_PATTERNS.
REQ-032 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-033 rst_ni low SHALL asynchronously force IDLE, both counters 0, and every output 0.
REQ-034 Reset deassertion mid-session SHALL NOT resume; a new start_i is required.

Structure
REQ-035 lbist_pkg SHALL hold the state enum and default CHAIN_LEN/N_PATTERNS/MISR_W constants.
REQ-036 One sub-module lbist_counter (parameterised width, clear, enable, terminal-count flag) SHALL be instantiated for the shift and pattern counters.

Verification
REQ-037 CHAIN_LEN=4, N_PATTERNS=3, misr_sig_i=GOLDEN_SIG, start pulse → done_o rises 21 cycles later, go_nogo_o=1, pattern_cnt_o=3.
REQ-038 Same run, misr_sig_i=GOLDEN_SIG^1 → done_o at 21 cycles, go_nogo_o=0.
REQ-039 Per-cycle check: test_en_o high exactly 4 cycles per SHIFT/UNLOAD; misr_step_o low during first SHIFT, 12 total high cycles (8 SHIFT + 4 UNLOAD).
REQ-040 test_normal_i dropped at cycle 7 → IDLE next edge, all outputs 0, done_o never rises.
REQ-041 rst_ni low mid-SHIFT → outputs 0 immediately (asynchronous); after release, no activity until start_i.
REQ-042 start_i held high through a session and test_normal_i=0 before start → no restart while busy; no session started.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared definitions for the logic-BIST sequencer: sequencer states, default
// geometry and the packed control-strobe bundle driven towards PRPG/MISR/core.
package lbist_pkg;

  localparam int unsigned LBIST_CHAIN_LEN  = 64;
  localparam int unsigned LBIST_N_PATTERNS = 1024;
  localparam int unsigned LBIST_MISR_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } lbist_state_e;

  typedef struct packed {
    logic test_en;
    logic pi_sel;
    logic prpg_load;
    logic prpg_step;
    logic misr_clear;
    logic misr_step;
    logic busy;
    logic done;
  } lbist_ctrl_t;

endpackage

// File: rtl/lbist_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag; at MAX it
// either wraps to zero or saturates.
module lbist_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1,
  parameter bit               WRAP  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == MAX) begin
        cnt_d = WRAP ? '0 : cnt_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == MAX);

endmodule

// File: rtl/lbist_sequencer.sv
// Logic-BIST session controller: seeds PRPG/MISR, runs N_PATTERNS shift/capture
// loops, unloads the last response and grades the MISR signature.
module lbist_sequencer
  import lbist_pkg::*;
#(
  parameter int unsigned       CHAIN_LEN  = LBIST_CHAIN_LEN,
  parameter int unsigned       N_PATTERNS = LBIST_N_PATTERNS,
  parameter int unsigned       MISR_W     = LBIST_MISR_W,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              test_normal_i,
  input  logic                              start_i,
  input  logic [MISR_W-1:0]                 misr_sig_i,
  output logic                              test_en_o,
  output logic                              pi_sel_o,
  output logic                              prpg_load_o,
  output logic                              prpg_step_o,
  output logic                              misr_clear_o,
  output logic                              misr_step_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              go_nogo_o,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt_o
);

  localparam int unsigned SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PW = $clog2(N_PATTERNS + 1);

  lbist_state_e   state_q, state_d;
  lbist_ctrl_t    ctrl_q, ctrl_d;
  logic           go_q, go_d;
  logic           busy_st, abort;
  logic           sh_clr, sh_en, sh_tc;
  logic [SW-1:0]  sh_cnt_unused;
  logic           pat_clr, pat_en, pat_tc;
  logic [PW-1:0]  pat_cnt;

  assign busy_st = state_q inside {ST_SEED, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_COMPARE};
  assign abort   = busy_st && !test_normal_i;

  // Next-state: any busy state falls back to IDLE when test mode is withdrawn.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i && test_normal_i) state_d = ST_SEED;
      ST_SEED:    state_d = ST_SHIFT;
      ST_SHIFT:   if (sh_tc) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (pat_cnt < PW'(N_PATTERNS - 1)) ? ST_SHIFT : ST_UNLOAD;
      ST_UNLOAD:  if (sh_tc) state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_DONE;
      ST_DONE: begin
        if (!test_normal_i)  state_d = ST_IDLE;
        else if (start_i)    state_d = ST_SEED;
      end
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  assign sh_clr  = abort || (state_q == ST_SEED);
  assign sh_en   = state_q inside {ST_SHIFT, ST_UNLOAD};
  assign pat_clr = abort || (state_d == ST_SEED);
  assign pat_en  = (state_q == ST_CAPTURE) && !pat_tc;

  // Strobes are registered from the next state; the first SHIFT after SEED
  // unloads garbage and is kept out of the MISR.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.test_en    = state_d inside {ST_SHIFT, ST_UNLOAD};
    ctrl_d.prpg_step  = ctrl_d.test_en;
    ctrl_d.pi_sel     = state_d inside {ST_SEED, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_COMPARE};
    ctrl_d.busy       = ctrl_d.pi_sel;
    ctrl_d.prpg_load  = (state_d == ST_SEED);
    ctrl_d.misr_clear = (state_d == ST_SEED);
    ctrl_d.done       = (state_d == ST_DONE);
    ctrl_d.misr_step  = (state_d == ST_UNLOAD) ||
                        ((state_d == ST_SHIFT) &&
                         ((state_q == ST_CAPTURE) || ((state_q == ST_SHIFT) && (pat_cnt != '0))));

    go_d = go_q;
    if ((state_q == ST_COMPARE) && !abort) go_d = (misr_sig_i == GOLDEN_SIG);
    if (abort || (state_d == ST_SEED))     go_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      go_q    <= go_d;
    end
  end

  lbist_counter #(
    .WIDTH (SW),
    .MAX   (SW'(CHAIN_LEN - 1)),
    .WRAP  (1'b1)
  ) u_shift_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (sh_clr),
    .en_i   (sh_en),
    .cnt_o  (sh_cnt_unused),
    .tc_o   (sh_tc)
  );

  lbist_counter #(
    .WIDTH (PW),
    .MAX   (PW'(N_PATTERNS)),
    .WRAP  (1'b0)
  ) u_pattern_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (pat_clr),
    .en_i   (pat_en),
    .cnt_o  (pat_cnt),
    .tc_o   (pat_tc)
  );

  assign test_en_o     = ctrl_q.test_en;
  assign pi_sel_o      = ctrl_q.pi_sel;
  assign prpg_load_o   = ctrl_q.prpg_load;
  assign prpg_step_o   = ctrl_q.prpg_step;
  assign misr_clear_o  = ctrl_q.misr_clear;
  assign misr_step_o   = ctrl_q.misr_step;
  assign busy_o        = ctrl_q.busy;
  assign done_o        = ctrl_q.done;
  assign go_nogo_o     = go_q;
  assign pattern_cnt_o = pat_cnt;

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer with CHAIN_LEN=4, N_PATTERNS=3: a per-cycle
// expected table for one session plus restart, abort, reset and gating sequences.
module tb_lbist_sequencer;

  localparam int unsigned C  = 4;
  localparam int unsigned N  = 3;
  localparam int unsigned MW = 32;
  localparam logic [MW-1:0] GOLD = 32'hA5C3_0F1E;
  localparam int LAST = 21;

  logic          clk = 1'b0;
  logic          rst_n, tn, start;
  logic [MW-1:0] sig;
  logic          test_en, pi_sel, prpg_load, prpg_step, misr_clear, misr_step;
  logic          busy, done, go;
  logic [1:0]    pcnt;
  logic [7:0]    obs;

  always #5 clk = ~clk;

  lbist_sequencer #(
    .CHAIN_LEN  (C),
    .N_PATTERNS (N),
    .MISR_W     (MW),
    .GOLDEN_SIG (GOLD)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_normal_i (tn),
    .start_i       (start),
    .misr_sig_i    (sig),
    .test_en_o     (test_en),
    .pi_sel_o      (pi_sel),
    .prpg_load_o   (prpg_load),
    .prpg_step_o   (prpg_step),
    .misr_clear_o  (misr_clear),
    .misr_step_o   (misr_step),
    .busy_o        (busy),
    .done_o        (done),
    .go_nogo_o     (go),
    .pattern_cnt_o (pcnt)
  );

  // {test_en, pi_sel, prpg_load, prpg_step, misr_clear, misr_step, busy, done}
  assign obs = {test_en, pi_sel, prpg_load, prpg_step, misr_clear, misr_step, busy, done};

  typedef struct {
    int         len;
    logic [7:0] outs;
    logic [1:0] cnt;
  } phase_t;

  typedef struct {
    logic [7:0] outs;
    logic [1:0] cnt;
  } vec_t;

  phase_t ph[10];
  vec_t   vec[LAST+1];
  int     errors = 0;
  int     checks = 0;
  int     ten, mst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rows 0..last after the start-sampling edge; row 0 is SEED, row 21 is DONE.
  task automatic run_rows(input string tag, input int last, input logic exp_go,
                          input logic hold, output int n_ten, output int n_mst);
    logic exp_g;
    n_ten = 0;
    n_mst = 0;
    for (int k = 0; k <= last; k++) begin
      step();
      if (!hold && k == 0) start = 1'b0;
      exp_g = (k == LAST) ? exp_go : 1'b0;
      chk($sformatf("%s_row%0d", tag, k), 32'({obs, go, pcnt}),
          32'({vec[k].outs, exp_g, vec[k].cnt}));
      n_ten += int'(test_en);
      n_mst += int'(misr_step);
    end
  endtask

  initial begin
    int idx;
    ph[0] = '{1, 8'b0110_1010, 2'd0};  // SEED
    ph[1] = '{4, 8'b1101_0010, 2'd0};  // first SHIFT, not compacted
    ph[2] = '{1, 8'b0100_0010, 2'd0};  // CAPTURE
    ph[3] = '{4, 8'b1101_0110, 2'd1};  // SHIFT
    ph[4] = '{1, 8'b0100_0010, 2'd1};  // CAPTURE
    ph[5] = '{4, 8'b1101_0110, 2'd2};  // SHIFT
    ph[6] = '{1, 8'b0100_0010, 2'd2};  // CAPTURE
    ph[7] = '{4, 8'b1101_0110, 2'd3};  // UNLOAD
    ph[8] = '{1, 8'b0100_0010, 2'd3};  // COMPARE
    ph[9] = '{1, 8'b0000_0001, 2'd3};  // DONE
    idx = 0;
    for (int p = 0; p < 10; p++) begin
      for (int r = 0; r < ph[p].len; r++) begin
        vec[idx] = '{ph[p].outs, ph[p].cnt};
        idx++;
      end
    end

    rst_n = 1'b1; tn = 1'b1; start = 1'b0; sig = GOLD;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_outputs", 32'({obs, go, pcnt}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    chk("idle_after_reset", 32'({obs, go, pcnt}), 32'd0);

    // Signature mismatch session from IDLE.
    sig = GOLD ^ 32'd1;
    start = 1'b1;
    run_rows("mis", LAST, 1'b0, 1'b0, ten, mst);
    chk("mis_test_en_cycles", 32'(ten), 32'd16);
    chk("mis_misr_step_cycles", 32'(mst), 32'd12);

    // Matching session restarted directly from DONE.
    sig = GOLD;
    start = 1'b1;
    run_rows("gold", LAST, 1'b1, 1'b0, ten, mst);
    chk("gold_test_en_cycles", 32'(ten), 32'd16);
    chk("gold_misr_step_cycles", 32'(mst), 32'd12);
    step(); step();
    chk("done_held", 32'({obs, go, pcnt}), 32'({8'b0000_0001, 1'b1, 2'd3}));

    // Leaving DONE for functional mode keeps the verdict.
    tn = 1'b0;
    step();
    chk("done_to_idle_go_held", 32'({obs, go}), 32'({8'd0, 1'b1}));

    // New session clears go_nogo in SEED, then abort at cycle 7.
    tn = 1'b1;
    start = 1'b1;
    run_rows("abt", 6, 1'b0, 1'b0, ten, mst);
    tn = 1'b0;
    step();
    chk("abort_outputs", 32'({obs, go, pcnt}), 32'd0);
    tn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      chk($sformatf("abort_quiet%0d", k), 32'({obs, go, pcnt}), 32'd0);
    end

    // Asynchronous reset in the middle of the first SHIFT.
    start = 1'b1;
    run_rows("rst", 2, 1'b0, 1'b0, ten, mst);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({obs, go, pcnt}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("post_reset_quiet%0d", k), 32'({obs, go, pcnt}), 32'd0);
    end

    // start held high: ignored in functional mode, not restarting while busy.
    tn = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("func_mode_gate%0d", k), 32'({obs, go, pcnt}), 32'd0);
    end
    tn = 1'b1;
    run_rows("hold", LAST, 1'b1, 1'b1, ten, mst);
    start = 1'b0;
    step();
    chk("hold_done_stays", 32'({obs, go, pcnt}), 32'({8'b0000_0001, 1'b1, 2'd3}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
